// File: rtl/uart_tx_frame_if.sv
// Byte-in / serial-out bundle between a byte source and the UART TX framer.
// Latency: none, wires only.
// Backpressure: the source may present a new byte only while Busy is low.
interface uart_tx_frame_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  Data_Valid;
  logic                  PAR_EN;
  logic                  par_bit;
  logic                  TX_OUT;
  logic                  Busy;

  // Byte source side
  modport master (
    output P_DATA, Data_Valid, PAR_EN, par_bit,
    input  TX_OUT, Busy
  );

  // Serializer side
  modport slave (
    input  P_DATA, Data_Valid, PAR_EN, par_bit,
    output TX_OUT, Busy
  );
endinterface

// File: rtl/uart_tx_frame.sv
// UART TX framer: start bit, data LSB first, optional parity bit, stop bit; one bit per CLK.
// Latency: byte accepted in cycle N drives the start bit (TX_OUT=0, Busy=1) in cycle N+1.
// Backpressure: Data_Valid is only honoured in IDLE; requests during a frame are dropped.
// Build option: define UART_TX_TWO_STOP_EN for two stop bits instead of one.
module uart_tx_frame #(
  parameter int DATA_WIDTH = 8
) (
  input logic          CLK,
  input logic          RST,
  uart_tx_frame_if.slave bus
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  par_q, par_d;
  logic                  par_en_q, par_en_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
`ifdef UART_TX_TWO_STOP_EN
  logic                  stop_cnt_q, stop_cnt_d;
`endif

  // Next-state logic, then line/busy values derived from the state being entered
  // so that both outputs can be registered and stay aligned with each other.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    par_d    = par_q;
    par_en_d = par_en_q;
`ifdef UART_TX_TWO_STOP_EN
    stop_cnt_d = stop_cnt_q;
`endif

    case (state_q)
      IDLE: begin
        // par_bit is only meaningful while Data_Valid is high, so grab it now.
        if (bus.Data_Valid) begin
          state_d  = START;
          shift_d  = bus.P_DATA;
          par_d    = bus.par_bit;
          par_en_d = bus.PAR_EN;
        end
      end
      START: begin
        state_d = DATA;
        cnt_d   = '0;
      end
      DATA: begin
        if (cnt_q == LAST_BIT) begin
          state_d = par_en_q ? PARITY : STOP;
        end else begin
          cnt_d   = cnt_q + CW'(1);
          shift_d = shift_q >> 1;
        end
      end
      PARITY: begin
        state_d = STOP;
      end
      STOP: begin
`ifdef UART_TX_TWO_STOP_EN
        if (!stop_cnt_q) begin
          stop_cnt_d = 1'b1;
        end else begin
          stop_cnt_d = 1'b0;
          state_d    = IDLE;
        end
`else
        state_d = IDLE;
`endif
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Line is high in IDLE and STOP; Busy covers every state except IDLE.
    tx_d   = 1'b1;
    busy_d = 1'b1;
    case (state_d)
      IDLE:    busy_d = 1'b0;
      START:   tx_d   = 1'b0;
      DATA:    tx_d   = shift_d[0];
      PARITY:  tx_d   = par_d;
      default: tx_d   = 1'b1;
    endcase
  end

  // State and output registers; reset wins over any simultaneous request.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      par_en_q <= 1'b0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
`ifdef UART_TX_TWO_STOP_EN
      stop_cnt_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      par_en_q <= par_en_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
`ifdef UART_TX_TWO_STOP_EN
      stop_cnt_q <= stop_cnt_d;
`endif
    end
  end

  assign bus.TX_OUT = tx_q;
  assign bus.Busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Self-checking bench for uart_tx_frame: directed and random frames against a frame-level model.
// Latency: expects the start bit one cycle after the accepting edge.
// Backpressure: checks that requests during a frame are ignored and back-to-back gaps are one cycle.
module tb_uart_tx_frame;

  localparam int DW = 8;
`ifdef UART_TX_TWO_STOP_EN
  localparam int N_STOP = 2;
`else
  localparam int N_STOP = 1;
`endif

  logic CLK = 1'b0;
  logic RST;

  uart_tx_frame_if #(.DATA_WIDTH(DW)) bus ();

  uart_tx_frame #(.DATA_WIDTH(DW)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  int vectors     = 0;
  int miscompares = 0;
  bit exp_q[$];

  // Frame as it should appear on the line: start, data LSB first, optional parity, stop bit(s).
  function automatic void build_frame(input logic [DW-1:0] d, input bit pe, input bit pb);
    exp_q.delete();
    exp_q.push_back(1'b0);
    for (int i = 0; i < DW; i++) exp_q.push_back(d[i]);
    if (pe) exp_q.push_back(pb);
    for (int i = 0; i < N_STOP; i++) exp_q.push_back(1'b1);
  endfunction

  // Present one byte for a single cycle; returns at the negedge where the start bit is visible.
  task automatic present(input logic [DW-1:0] d, input bit pe, input bit pb);
    @(negedge CLK);
    bus.P_DATA     = d;
    bus.PAR_EN     = pe;
    bus.par_bit    = pb;
    bus.Data_Valid = 1'b1;
    @(negedge CLK);
    bus.Data_Valid = 1'b0;
    bus.par_bit    = 1'b0;
  endtask

  task automatic test_reset();
    RST            = 1'b1;
    bus.Data_Valid = 1'b1;
    bus.P_DATA     = DW'($urandom);
    bus.PAR_EN     = 1'b1;
    bus.par_bit    = 1'b1;
    repeat (2) @(negedge CLK);
    vectors++;
    if (bus.TX_OUT !== 1'b1 || bus.Busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_with_valid: tx=%b busy=%b, want tx=1 busy=0", bus.TX_OUT, bus.Busy);
    end
    RST            = 1'b0;
    bus.Data_Valid = 1'b0;
    bus.par_bit    = 1'b0;
    repeat (2) @(negedge CLK);
    vectors++;
    if (bus.TX_OUT !== 1'b1 || bus.Busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_idle: tx=%b busy=%b, want tx=1 busy=0", bus.TX_OUT, bus.Busy);
    end
  endtask

  task automatic test_directed_frames();
    logic [DW-1:0] d_tab [4] = '{8'hA5, 8'hA5, 8'h01, 8'h00};
    bit            pe_tab[4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    bit            pb_tab[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    for (int k = 0; k < 4; k++) begin
      build_frame(d_tab[k], pe_tab[k], pb_tab[k]);
      present(d_tab[k], pe_tab[k], pb_tab[k]);
      for (int i = 0; i < exp_q.size(); i++) begin
        vectors++;
        if (bus.TX_OUT !== exp_q[i] || bus.Busy !== 1'b1) begin
          miscompares++;
          $display("FAIL directed_%0d bit %0d: tx=%b busy=%b, want tx=%b busy=1",
                   k, i, bus.TX_OUT, bus.Busy, exp_q[i]);
        end
        @(negedge CLK);
      end
      vectors++;
      if (bus.TX_OUT !== 1'b1 || bus.Busy !== 1'b0) begin
        miscompares++;
        $display("FAIL directed_%0d_end: tx=%b busy=%b, want tx=1 busy=0", k, bus.TX_OUT, bus.Busy);
      end
    end
  endtask

  task automatic test_ignore_busy();
    build_frame(8'hA5, 1'b1, 1'b0);
    present(8'hA5, 1'b1, 1'b0);
    for (int i = 0; i < exp_q.size(); i++) begin
      vectors++;
      if (bus.TX_OUT !== exp_q[i] || bus.Busy !== 1'b1) begin
        miscompares++;
        $display("FAIL ignore_busy bit %0d: tx=%b busy=%b, want tx=%b busy=1",
                 i, bus.TX_OUT, bus.Busy, exp_q[i]);
      end
      if (i == 3) begin
        bus.Data_Valid = 1'b1;
        bus.P_DATA     = 8'h3C;
        bus.PAR_EN     = 1'b0;
        bus.par_bit    = 1'b1;
      end else if (i == 4) begin
        bus.Data_Valid = 1'b0;
        bus.par_bit    = 1'b0;
      end
      @(negedge CLK);
    end
    for (int j = 0; j < 4; j++) begin
      vectors++;
      if (bus.TX_OUT !== 1'b1 || bus.Busy !== 1'b0) begin
        miscompares++;
        $display("FAIL ignore_busy_after %0d: tx=%b busy=%b, want tx=1 busy=0", j, bus.TX_OUT, bus.Busy);
      end
      @(negedge CLK);
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] bytes[2] = '{8'h55, 8'hFF};
    @(negedge CLK);
    bus.P_DATA     = bytes[0];
    bus.PAR_EN     = 1'b0;
    bus.Data_Valid = 1'b1;
    @(negedge CLK);
    bus.P_DATA = bytes[1];
    for (int f = 0; f < 2; f++) begin
      build_frame(bytes[f], 1'b0, 1'b0);
      for (int i = 0; i < exp_q.size(); i++) begin
        vectors++;
        if (bus.TX_OUT !== exp_q[i] || bus.Busy !== 1'b1) begin
          miscompares++;
          $display("FAIL back_to_back f%0d bit %0d: tx=%b busy=%b, want tx=%b busy=1",
                   f, i, bus.TX_OUT, bus.Busy, exp_q[i]);
        end
        if (f == 1 && i == 0) bus.Data_Valid = 1'b0;
        @(negedge CLK);
      end
      vectors++;
      if (bus.TX_OUT !== 1'b1 || bus.Busy !== 1'b0) begin
        miscompares++;
        $display("FAIL back_to_back_gap f%0d: tx=%b busy=%b, want tx=1 busy=0", f, bus.TX_OUT, bus.Busy);
      end
      @(negedge CLK);
    end
    vectors++;
    if (bus.TX_OUT !== 1'b1 || bus.Busy !== 1'b0) begin
      miscompares++;
      $display("FAIL back_to_back_tail: tx=%b busy=%b, want tx=1 busy=0", bus.TX_OUT, bus.Busy);
    end
  endtask

  task automatic test_reset_midframe();
    logic [DW-1:0] d;
    bit            pb;
    d = DW'($urandom);
    build_frame(d, 1'b1, 1'b1);
    present(d, 1'b1, 1'b1);
    for (int i = 0; i <= 5; i++) begin
      vectors++;
      if (bus.TX_OUT !== exp_q[i] || bus.Busy !== 1'b1) begin
        miscompares++;
        $display("FAIL reset_mid bit %0d: tx=%b busy=%b, want tx=%b busy=1",
                 i, bus.TX_OUT, bus.Busy, exp_q[i]);
      end
      if (i < 5) @(negedge CLK);
    end
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    for (int j = 0; j < 3; j++) begin
      vectors++;
      if (bus.TX_OUT !== 1'b1 || bus.Busy !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_mid_abort %0d: tx=%b busy=%b, want tx=1 busy=0", j, bus.TX_OUT, bus.Busy);
      end
      @(negedge CLK);
    end
    pb = 1'($urandom);
    build_frame(8'h0F, 1'b1, pb);
    present(8'h0F, 1'b1, pb);
    for (int i = 0; i < exp_q.size(); i++) begin
      vectors++;
      if (bus.TX_OUT !== exp_q[i] || bus.Busy !== 1'b1) begin
        miscompares++;
        $display("FAIL reset_mid_refill bit %0d: tx=%b busy=%b, want tx=%b busy=1",
                 i, bus.TX_OUT, bus.Busy, exp_q[i]);
      end
      @(negedge CLK);
    end
    vectors++;
    if (bus.TX_OUT !== 1'b1 || bus.Busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_refill_end: tx=%b busy=%b, want tx=1 busy=0", bus.TX_OUT, bus.Busy);
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] d;
    bit            pe, pb;
    for (int k = 0; k < 24; k++) begin
      d  = DW'($urandom);
      pe = 1'($urandom);
      pb = 1'($urandom);
      build_frame(d, pe, pb);
      present(d, pe, pb);
      for (int i = 0; i < exp_q.size(); i++) begin
        vectors++;
        if (bus.TX_OUT !== exp_q[i] || bus.Busy !== 1'b1) begin
          miscompares++;
          $display("FAIL random_%0d d=%h pe=%b bit %0d: tx=%b busy=%b, want tx=%b busy=1",
                   k, d, pe, i, bus.TX_OUT, bus.Busy, exp_q[i]);
        end
        // Scramble inputs mid-frame; the frame must not change.
        bus.P_DATA  = DW'($urandom);
        bus.PAR_EN  = 1'($urandom);
        @(negedge CLK);
      end
      repeat ($urandom_range(0, 2)) begin
        vectors++;
        if (bus.TX_OUT !== 1'b1 || bus.Busy !== 1'b0) begin
          miscompares++;
          $display("FAIL random_%0d_idle: tx=%b busy=%b, want tx=1 busy=0", k, bus.TX_OUT, bus.Busy);
        end
        @(negedge CLK);
      end
    end
  endtask

  initial begin
    RST            = 1'b1;
    bus.Data_Valid = 1'b0;
    bus.P_DATA     = '0;
    bus.PAR_EN     = 1'b0;
    bus.par_bit    = 1'b0;
    test_reset();
    test_directed_frames();
    test_ignore_busy();
    test_back_to_back();
    test_reset_midframe();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
